// File: rtl/fb_master.sv
// rtl/fb_master.sv - FlexBus initiator: valid/ready requests to multiplexed ALE/CS bus cycles
// Define FB_MASTER_ADDR_CHECK_EN to reject addresses outside the FB_BASE[31:28] window.
module fb_master #(
    parameter logic [31:0] FB_BASE     = 32'h6000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        FB_CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        FB_ALE,
    output logic        FB_CS,
    output logic        FB_RW,
    inout  wire  [31:0] FB_AD
);

`ifdef FB_MASTER_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif
    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  wait_cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        rw_q;
    logic        err_q;
    logic        ad_oe;
    logic        accept;
    logic        addr_bad;

    assign accept   = req_valid && req_ready;
    assign addr_bad = ADDR_CHECK && (req_addr[31:28] != FB_BASE[31:28]);

    always_ff @(posedge FB_CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = addr_bad ? HOLD : ADDR;
            ADDR: state_next = DATA;
            DATA: if (wait_cnt == 4'd0) state_next = HOLD;
            HOLD: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Read data is captured on the edge that ends the last data cycle.
    always_ff @(posedge FB_CLK or posedge RST) begin
        if (RST) begin
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            rw_q      <= 1'b1;
            err_q     <= 1'b0;
            wait_cnt  <= 4'd0;
            rsp_rdata <= 32'h0;
        end else begin
            if (accept) begin
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                rw_q     <= req_rw;
                err_q    <= addr_bad;
                wait_cnt <= WS_INIT;
            end else if (state == DATA && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (state == DATA && wait_cnt == 4'd0 && rw_q) begin
                rsp_rdata <= FB_AD;
            end
        end
    end

    // HOLD never drives FB_AD, giving the slave a turnaround cycle.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        FB_ALE    = 1'b0;
        FB_CS     = 1'b1;
        FB_RW     = 1'b1;
        ad_oe     = 1'b0;
        unique case (state)
            IDLE: req_ready = !RST;
            ADDR: begin
                FB_ALE = 1'b1;
                FB_RW  = rw_q;
                ad_oe  = 1'b1;
            end
            DATA: begin
                FB_CS = 1'b0;
                FB_RW = rw_q;
                ad_oe = !rw_q;
            end
            HOLD: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
            end
            default: ;
        endcase
    end

    assign FB_AD = ad_oe ? ((state == ADDR) ? addr_q : wdata_q) : 32'bz;

endmodule

// File: tb/tb_fb_master.sv
// tb/tb_fb_master.sv - self-checking bench for fb_master with WAIT_STATES=1 and WAIT_STATES=3 instances
// Honours FB_MASTER_ADDR_CHECK_EN when the design is built with it.
module tb_fb_master;

`ifdef FB_MASTER_ADDR_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclr = 1'b1;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_rw    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic        fb_ale    [2];
    logic        fb_cs     [2];
    logic        fb_rw     [2];
    wire  [31:0] fb_ad0;
    wire  [31:0] fb_ad1;

    logic [31:0] smem0 [16];
    logic [31:0] smem1 [16];
    logic [3:0]  sidx0;
    logic [3:0]  sidx1;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    fb_master #(.FB_BASE(32'h6000_0000), .WAIT_STATES(1)) u_ws1 (
        .FB_CLK(clk), .RST(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_rw(req_rw[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .FB_ALE(fb_ale[0]), .FB_CS(fb_cs[0]), .FB_RW(fb_rw[0]), .FB_AD(fb_ad0)
    );

    fb_master #(.FB_BASE(32'h6000_0000), .WAIT_STATES(3)) u_ws3 (
        .FB_CLK(clk), .RST(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_rw(req_rw[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .FB_ALE(fb_ale[1]), .FB_CS(fb_cs[1]), .FB_RW(fb_rw[1]), .FB_AD(fb_ad1)
    );

    // Register-slave models: latch word index on ALE, write every CS-low write cycle.
    assign fb_ad0 = (!fb_cs[0] && fb_rw[0]) ? smem0[sidx0] : 32'bz;
    assign fb_ad1 = (!fb_cs[1] && fb_rw[1]) ? smem1[sidx1] : 32'bz;

    always @(posedge clk) begin
        if (sclr) begin
            for (int i = 0; i < 16; i++) begin
                smem0[i] <= 32'h0;
                smem1[i] <= 32'h0;
            end
        end else begin
            if (fb_ale[0]) sidx0 <= fb_ad0[5:2];
            if (fb_ale[1]) sidx1 <= fb_ad1[5:2];
            if (!fb_cs[0] && !fb_rw[0]) smem0[sidx0] <= fb_ad0;
            if (!fb_cs[1] && !fb_rw[1]) smem1[sidx1] <= fb_ad1;
        end
    end

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic released(input logic [31:0] v);
        return $isunknown(v) || (v == 32'h0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: each transaction is a timeline of cycle offsets from its accept cycle.
    int          acc_cyc   [2];
    logic [31:0] p_addr    [2];
    logic [31:0] p_wdata   [2];
    logic        p_rw      [2];
    logic        p_err     [2];
    logic [31:0] mem_exp   [2][16];
    logic [31:0] rdata_exp [2];

    task automatic check_dut(input int d);
        int          ws;
        int          off;
        int          blen;
        logic        ale_e;
        logic        csl_e;
        logic        hold_e;
        logic        busy_e;
        logic [31:0] ad;
        string       p;
        ad = (d == 0) ? fb_ad0 : fb_ad1;
        p  = (d == 0) ? "ws1" : "ws3";
        ws = ws_of(d);
        if (rst) begin
            acc_cyc[d]   = -1000;
            rdata_exp[d] = 32'h0;
            chk({p, " rst req_ready"}, req_ready[d], 0);
            chk({p, " rst cs"}, fb_cs[d], 1);
            chk({p, " rst ale"}, fb_ale[d], 0);
            chk({p, " rst rw"}, fb_rw[d], 1);
            chk({p, " rst rsp_valid"}, rsp_valid[d], 0);
            chk({p, " rst rsp_err"}, rsp_err[d], 0);
            chk({p, " rst rsp_rdata"}, rsp_rdata[d], 0);
            chk({p, " rst bus released"}, released(ad), 1);
            return;
        end
        off    = cyc - acc_cyc[d];
        blen   = p_err[d] ? 1 : ws + 3;
        ale_e  = !p_err[d] && off == 1;
        csl_e  = !p_err[d] && off >= 2 && off <= ws + 2;
        hold_e = off == blen;
        busy_e = off >= 1 && off <= blen;
        if (hold_e && !p_err[d]) begin
            if (p_rw[d]) rdata_exp[d] = mem_exp[d][p_addr[d][5:2]];
            else         mem_exp[d][p_addr[d][5:2]] = p_wdata[d];
        end
        chk({p, " req_ready"}, req_ready[d], !busy_e);
        chk({p, " ale"}, fb_ale[d], ale_e);
        chk({p, " cs"}, fb_cs[d], !csl_e);
        chk({p, " rw"}, fb_rw[d], (ale_e || csl_e) ? p_rw[d] : 1'b1);
        chk({p, " rsp_valid"}, rsp_valid[d], hold_e);
        chk({p, " rsp_err"}, rsp_err[d], hold_e && p_err[d]);
        chk({p, " rsp_rdata"}, rsp_rdata[d], rdata_exp[d]);
        if (ale_e)      chk({p, " ad addr"}, ad, p_addr[d]);
        else if (csl_e) chk({p, " ad data"}, ad, p_rw[d] ? mem_exp[d][p_addr[d][5:2]] : p_wdata[d]);
        else            chk({p, " bus released"}, released(ad), 1);
        if (req_valid[d] && !busy_e) begin
            acc_cyc[d] = cyc;
            p_addr[d]  = req_addr[d];
            p_wdata[d] = req_wdata[d];
            p_rw[d]    = req_rw[d];
            p_err[d]   = CHECK && (req_addr[d][31:28] != 4'h6);
        end
    endtask

    initial begin : monitor
        for (int d = 0; d < 2; d++) begin
            acc_cyc[d]   = -1000;
            p_addr[d]    = 32'h0;
            p_wdata[d]   = 32'h0;
            p_rw[d]      = 1'b1;
            p_err[d]     = 1'b0;
            rdata_exp[d] = 32'h0;
            for (int i = 0; i < 16; i++) mem_exp[d][i] = 32'h0;
        end
        forever begin
            @(negedge clk);
            check_dut(0);
            check_dut(1);
        end
    end

    task automatic issue(input int d, input logic rw, input logic [31:0] addr,
                         input logic [31:0] wdata, output int acc);
        int n;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        req_rw[d]    = rw;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_valid[d] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[d] && n < 40);
        chk("issue accept", req_ready[d], 1);
        acc = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_rsp(input int d, input int acc, input int lat, input logic err,
                            input logic [31:0] rdata, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!rsp_valid[d] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, " rsp seen"}, rsp_valid[d], 1);
        chk({name, " latency"}, cyc - acc, lat);
        chk({name, " err"}, rsp_err[d], err);
        chk({name, " rdata"}, rsp_rdata[d], rdata);
    endtask

    typedef struct {
        int          d;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    initial begin : stim
        vec_t        tbl [$];
        int          acc;
        int          a1;
        int          a2;
        int          a3;
        int          d;
        logic        rw;
        logic [3:0]  nib;
        logic [3:0]  slot;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_rw[i]    = 1'b1;
            req_addr[i]  = 32'h0;
            req_wdata[i] = 32'h0;
        end

        tbl.push_back('{0, 1'b0, 32'h6000_0008, 32'h1234_5678, 4, 1'b0, 32'h0});
        tbl.push_back('{0, 1'b1, 32'h6000_0008, 32'h0,         4, 1'b0, 32'h1234_5678});
        if (CHECK) tbl.push_back('{0, 1'b1, 32'h7000_0000, 32'h0, 1, 1'b1, 32'h1234_5678});
        else       tbl.push_back('{0, 1'b1, 32'h7000_0000, 32'h0, 4, 1'b0, 32'h0});
        tbl.push_back('{1, 1'b0, 32'h6000_0010, 32'hA5A5_A5A5, 6, 1'b0, 32'h0});
        tbl.push_back('{1, 1'b1, 32'h6000_0010, 32'h0,         6, 1'b0, 32'hA5A5_A5A5});
        tbl.push_back('{1, 1'b0, 32'h6000_0004, 32'h0BAD_F00D, 6, 1'b0, 32'hA5A5_A5A5});
        tbl.push_back('{1, 1'b1, 32'h6000_0004, 32'h0,         6, 1'b0, 32'h0BAD_F00D});
        if (CHECK) begin
            tbl.push_back('{0, 1'b0, 32'h7000_000C, 32'hDEAD_BEEF, 1, 1'b1, 32'h1234_5678});
            tbl.push_back('{0, 1'b1, 32'h6000_000C, 32'h0,         4, 1'b0, 32'h0});
        end else begin
            tbl.push_back('{0, 1'b0, 32'h7000_000C, 32'hDEAD_BEEF, 4, 1'b0, 32'h0});
            tbl.push_back('{0, 1'b1, 32'h6000_000C, 32'h0,         4, 1'b0, 32'hDEAD_BEEF});
        end
        tbl.push_back('{0, 1'b1, 32'h6000_0004, 32'h0, 4, 1'b0, 32'h0});

        repeat (3) @(posedge clk);
        #1;
        rst  = 1'b0;
        sclr = 1'b0;
        idle(2);

        foreach (tbl[i]) begin
            issue(tbl[i].d, tbl[i].rw, tbl[i].addr, tbl[i].wdata, acc);
            idle(0);
            wait_rsp(tbl[i].d, acc, tbl[i].lat, tbl[i].err, tbl[i].rdata, $sformatf("vec%0d", i));
            idle(1);
        end

        // Back-to-back writes with req_valid held high throughout.
        issue(0, 1'b0, 32'h6000_0000, 32'h1111_0000, a1);
        issue(0, 1'b0, 32'h6000_0004, 32'h2222_0004, a2);
        issue(0, 1'b0, 32'h6000_0008, 32'h3333_0008, a3);
        idle(0);
        chk("b2b interval 1", a2 - a1, 5);
        chk("b2b interval 2", a3 - a2, 5);
        wait_rsp(0, a3, 4, 1'b0, 32'h0, "b2b last");
        idle(1);
        issue(0, 1'b1, 32'h6000_0000, 32'h0, acc);
        idle(0);
        wait_rsp(0, acc, 4, 1'b0, 32'h1111_0000, "b2b rd0");
        issue(0, 1'b1, 32'h6000_0004, 32'h0, acc);
        idle(0);
        wait_rsp(0, acc, 4, 1'b0, 32'h2222_0004, "b2b rd1");
        issue(0, 1'b1, 32'h6000_0008, 32'h0, acc);
        idle(0);
        wait_rsp(0, acc, 4, 1'b0, 32'h3333_0008, "b2b rd2");
        idle(1);

        // Reset asserted mid-way through the first data cycle of a write.
        issue(0, 1'b0, 32'h6000_0018, 32'h55AA_55AA, acc);
        idle(0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort cs", fb_cs[0], 1);
        chk("abort bus released", released(fb_ad0), 1);
        chk("abort rsp_valid", rsp_valid[0], 0);
        chk("abort req_ready", req_ready[0], 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
        issue(0, 1'b1, 32'h6000_0018, 32'h0, acc);
        idle(0);
        wait_rsp(0, acc, 4, 1'b0, 32'h0, "post-reset read");
        idle(1);

        for (int i = 0; i < 120; i++) begin
            d    = int'($urandom_range(0, 1));
            rw   = 1'($urandom_range(0, 1));
            nib  = ($urandom_range(0, 4) == 0) ? 4'h7 : 4'h6;
            slot = 4'($urandom_range(0, 15));
            issue(d, rw, {nib, 22'h0, slot, 2'b00}, $urandom, acc);
            if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(0, 3)));
        end
        idle(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        n_fail++;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
